// File: rtl/tri_wave_gen_if.sv
// rtl/tri_wave_gen_if.sv - config and sample bundle for tri_wave_gen (offset field under TRI_WAVE_GEN_OFFSET_EN)
interface tri_wave_gen_if #(
   parameter int data_width  = 12,
   parameter int range_width = 10
);
   logic                          enable;
   logic signed [data_width-1:0]  peak;
   logic        [data_width-2:0]  step;
   logic        [range_width-1:0] hold;
`ifdef TRI_WAVE_GEN_OFFSET_EN
   logic signed [data_width-1:0]  offset;
`endif
   logic signed [data_width-1:0]  data_out;
   logic                          period_start;
   logic                          peak_flag;
   logic                          err;

   // Config source side: drives run request and waveform settings, observes samples.
   modport master (
`ifdef TRI_WAVE_GEN_OFFSET_EN
      output offset,
`endif
      output enable, peak, step, hold,
      input  data_out, period_start, peak_flag, err
   );

   // Generator side.
   modport slave (
`ifdef TRI_WAVE_GEN_OFFSET_EN
      input  offset,
`endif
      input  enable, peak, step, hold,
      output data_out, period_start, peak_flag, err
   );
endinterface

// File: rtl/tri_wave_gen.sv
// rtl/tri_wave_gen.sv - signed triangle-wave source with dwell, strobes and optional offset (TRI_WAVE_GEN_OFFSET_EN)
module tri_wave_gen #(
   parameter int data_width  = 12,
   parameter int range_width = 10
) (
   input logic           clk_in,
   input logic           rst_n,
   tri_wave_gen_if.slave bus
);
   localparam int sw = data_width + 1;

   typedef enum logic [2:0] {IDLE, LO, RISE, HI, FALL} state_t;

   state_t                        state_q, state_d;
   logic signed [data_width-1:0]  ramp_q, ramp_d;
   logic signed [data_width-1:0]  peak_l, peak_d;
   logic        [data_width-2:0]  step_l, step_d;
   logic        [range_width-1:0] hold_l, hold_d;
   logic        [range_width-1:0] cnt_q, cnt_d;
   logic signed [data_width-1:0]  out_q, out_d;
   logic                          ps_q, ps_d, pf_q, pf_d, err_q, err_d;
   logic                          cfg_ok, lo_entry, hi_entry;
   logic signed [sw-1:0]          sum_w, diff_w, peak_w, npeak_w;
`ifdef TRI_WAVE_GEN_OFFSET_EN
   logic signed [data_width-1:0]  offset_l, offset_d;
   logic signed [sw-1:0]          biased_w;
`endif

   // Ramp arithmetic is one bit wider than the sample so overshoot is seen before clamping.
   always_comb begin
      cfg_ok  = (bus.peak > 0) && (bus.step != '0);
      peak_w  = {peak_l[data_width-1], peak_l};
      npeak_w = -peak_w;
      sum_w   = {ramp_q[data_width-1], ramp_q} + $signed({2'b00, step_l});
      diff_w  = {ramp_q[data_width-1], ramp_q} - $signed({2'b00, step_l});
   end

   // Next-state, next-sample and strobe decode; the registered outputs follow the next state.
   always_comb begin
      state_d  = state_q;
      ramp_d   = ramp_q;
      peak_d   = peak_l;
      step_d   = step_l;
      hold_d   = hold_l;
      cnt_d    = cnt_q;
      ps_d     = 1'b0;
      pf_d     = 1'b0;
      err_d    = 1'b0;
      lo_entry = 1'b0;
      hi_entry = 1'b0;
`ifdef TRI_WAVE_GEN_OFFSET_EN
      offset_d = offset_l;
      biased_w = '0;
`endif
      if (!bus.enable) begin
         state_d = IDLE;
         ramp_d  = '0;
      end else begin
         case (state_q)
            IDLE: lo_entry = 1'b1;
            LO: begin
               if (cnt_q != hold_l) cnt_d = cnt_q + {{(range_width-1){1'b0}}, 1'b1};
               else if (sum_w >= peak_w) hi_entry = 1'b1;
               else begin
                  state_d = RISE;
                  ramp_d  = sum_w[data_width-1:0];
               end
            end
            RISE: begin
               if (sum_w >= peak_w) hi_entry = 1'b1;
               else ramp_d = sum_w[data_width-1:0];
            end
            HI: begin
               if (cnt_q != hold_l) cnt_d = cnt_q + {{(range_width-1){1'b0}}, 1'b1};
               else if (diff_w <= npeak_w) lo_entry = 1'b1;
               else begin
                  state_d = FALL;
                  ramp_d  = diff_w[data_width-1:0];
               end
            end
            FALL: begin
               if (diff_w <= npeak_w) lo_entry = 1'b1;
               else ramp_d = diff_w[data_width-1:0];
            end
            default: begin
               state_d = IDLE;
               ramp_d  = '0;
            end
         endcase

         // Reaching the top saturates to the latched peak and counts as the first dwell cycle.
         if (hi_entry) begin
            state_d = HI;
            ramp_d  = peak_l;
            cnt_d   = '0;
            pf_d    = 1'b1;
         end

         // Every bottom entry re-latches the config; a bad config parks in IDLE with err.
         if (lo_entry) begin
            if (cfg_ok) begin
               state_d = LO;
               peak_d  = bus.peak;
               step_d  = bus.step;
               hold_d  = bus.hold;
               ramp_d  = -bus.peak;
               cnt_d   = '0;
               ps_d    = 1'b1;
`ifdef TRI_WAVE_GEN_OFFSET_EN
               offset_d = bus.offset;
`endif
            end else begin
               state_d = IDLE;
               ramp_d  = '0;
               err_d   = 1'b1;
            end
         end
      end

      if (state_d == IDLE) begin
         out_d = '0;
      end else begin
`ifdef TRI_WAVE_GEN_OFFSET_EN
         biased_w = {ramp_d[data_width-1], ramp_d} + {offset_d[data_width-1], offset_d};
         if (biased_w[sw-1] != biased_w[sw-2])
            out_d = biased_w[sw-1] ? {1'b1, {(data_width-1){1'b0}}} : {1'b0, {(data_width-1){1'b1}}};
         else
            out_d = biased_w[data_width-1:0];
`else
         out_d = ramp_d;
`endif
      end
   end

   // State and output registers; reset overrides a simultaneous enable.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ramp_q   <= '0;
         peak_l   <= '0;
         step_l   <= '0;
         hold_l   <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         ps_q     <= 1'b0;
         pf_q     <= 1'b0;
         err_q    <= 1'b0;
`ifdef TRI_WAVE_GEN_OFFSET_EN
         offset_l <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ramp_q   <= ramp_d;
         peak_l   <= peak_d;
         step_l   <= step_d;
         hold_l   <= hold_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         ps_q     <= ps_d;
         pf_q     <= pf_d;
         err_q    <= err_d;
`ifdef TRI_WAVE_GEN_OFFSET_EN
         offset_l <= offset_d;
`endif
      end
   end

   assign bus.data_out     = out_q;
   assign bus.period_start = ps_q;
   assign bus.peak_flag    = pf_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_tri_wave_gen.sv
// tb/tb_tri_wave_gen.sv - directed self-checking bench for tri_wave_gen
module tb_tri_wave_gen;
   logic clk_in = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

`ifdef TRI_WAVE_GEN_OFFSET_EN
   localparam int ext_bot = -1947;
   localparam int ext_mid = 100;
`else
   localparam int ext_bot = -2047;
   localparam int ext_mid = 0;
`endif

   tri_wave_gen_if #(.data_width(12), .range_width(10)) tw ();

   tri_wave_gen #(.data_width(12), .range_width(10)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (tw)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic idle_cfg(input int pk, input int st, input int hd);
      tw.enable = 1'b0;
      tw.peak   = 12'(pk);
      tw.step   = 11'(st);
      tw.hold   = 10'(hd);
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_cfg(4, 2, 1);
      tw.enable = 1'b1;
      tick();
      tick();
      checks++; if (tw.data_out !== 12'sd0) begin errors++; $display("FAIL reset_data got %0d exp 0", tw.data_out); end
      checks++; if (tw.period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b exp 0", tw.period_start); end
      checks++; if (tw.peak_flag !== 1'b0) begin errors++; $display("FAIL reset_pf got %b exp 0", tw.peak_flag); end
      checks++; if (tw.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", tw.err); end
      tw.enable = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_ramp();
      int exp_d[10] = '{-4, -4, -2, 0, 2, 4, 4, 2, 0, -2};
      idle_cfg(4, 2, 1);
      tw.enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++; if (tw.data_out !== exp_d[i % 10]) begin errors++; $display("FAIL basic_data[%0d] got %0d exp %0d", i, tw.data_out, exp_d[i % 10]); end
         checks++; if (tw.period_start !== ((i % 10) == 0)) begin errors++; $display("FAIL basic_ps[%0d] got %b", i, tw.period_start); end
         checks++; if (tw.peak_flag !== ((i % 10) == 5)) begin errors++; $display("FAIL basic_pf[%0d] got %b", i, tw.peak_flag); end
      end
   endtask

   task automatic test_saturation();
      int exp_d[6] = '{-4, -1, 2, 4, 1, -2};
      idle_cfg(4, 3, 0);
      tw.enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++; if (tw.data_out !== exp_d[i % 6]) begin errors++; $display("FAIL sat_data[%0d] got %0d exp %0d", i, tw.data_out, exp_d[i % 6]); end
         checks++; if (tw.period_start !== ((i % 6) == 0)) begin errors++; $display("FAIL sat_ps[%0d] got %b", i, tw.period_start); end
         checks++; if (tw.peak_flag !== ((i % 6) == 3)) begin errors++; $display("FAIL sat_pf[%0d] got %b", i, tw.peak_flag); end
      end
   endtask

   task automatic test_invalid_config();
      int bad_pk[3] = '{0, -3, 5};
      int bad_st[3] = '{2, 2, 0};
      int fall_d[4] = '{-2, 0, 2, 0};
      idle_cfg(0, 2, 0);
      tw.enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tw.peak = 12'(bad_pk[i]);
         tw.step = 11'(bad_st[i]);
         tick();
         checks++; if (tw.err !== 1'b1) begin errors++; $display("FAIL inv_err[%0d] got %b exp 1", i, tw.err); end
         checks++; if (tw.data_out !== 12'sd0) begin errors++; $display("FAIL inv_data[%0d] got %0d exp 0", i, tw.data_out); end
         checks++; if ((tw.period_start | tw.peak_flag) !== 1'b0) begin errors++; $display("FAIL inv_strobe[%0d] got %b%b exp 00", i, tw.period_start, tw.peak_flag); end
      end
      tw.peak = 12'sd5;
      tw.step = 11'd2;
      tick();
      checks++; if (tw.err !== 1'b0) begin errors++; $display("FAIL inv_recover_err got %b exp 0", tw.err); end
      checks++; if (tw.data_out !== -12'sd5) begin errors++; $display("FAIL inv_recover_data got %0d exp -5", tw.data_out); end
      checks++; if (tw.period_start !== 1'b1) begin errors++; $display("FAIL inv_recover_ps got %b exp 1", tw.period_start); end

      idle_cfg(2, 2, 0);
      tw.enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (tw.data_out !== fall_d[i]) begin errors++; $display("FAIL inv_fall_data[%0d] got %0d exp %0d", i, tw.data_out, fall_d[i]); end
         if (i == 1) tw.peak = 12'sd0;
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (tw.err !== 1'b1) begin errors++; $display("FAIL inv_fall_err[%0d] got %b exp 1", i, tw.err); end
         checks++; if (tw.data_out !== 12'sd0) begin errors++; $display("FAIL inv_fall_zero[%0d] got %0d exp 0", i, tw.data_out); end
         checks++; if (tw.period_start !== 1'b0) begin errors++; $display("FAIL inv_fall_ps[%0d] got %b exp 0", i, tw.period_start); end
      end
   endtask

   task automatic test_mid_period_change();
      int exp_d[18] = '{-4, -2, 0, 2, 4, 2, 0, -2, -4, -3, -2, -1, 0, 1, 2, 3, 4, 3};
      idle_cfg(4, 2, 0);
      tw.enable = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         checks++; if (tw.data_out !== exp_d[i]) begin errors++; $display("FAIL mid_data[%0d] got %0d exp %0d", i, tw.data_out, exp_d[i]); end
         checks++; if (tw.period_start !== (i == 0 || i == 8)) begin errors++; $display("FAIL mid_ps[%0d] got %b", i, tw.period_start); end
         checks++; if (tw.peak_flag !== (i == 4 || i == 16)) begin errors++; $display("FAIL mid_pf[%0d] got %b", i, tw.peak_flag); end
         if (i == 1) tw.step = 11'd1;
      end
   endtask

   task automatic test_abort(input bit use_reset);
      int exp_d[8] = '{-4, -4, -2, 0, 2, 4, 4, 2};
      idle_cfg(4, 2, 1);
      tw.enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (tw.data_out !== exp_d[i]) begin errors++; $display("FAIL abort%0d_data[%0d] got %0d exp %0d", use_reset, i, tw.data_out, exp_d[i]); end
      end
      if (use_reset) rst_n = 1'b0;
      else tw.enable = 1'b0;
      tick();
      checks++; if (tw.data_out !== 12'sd0) begin errors++; $display("FAIL abort%0d_zero got %0d exp 0", use_reset, tw.data_out); end
      checks++; if ((tw.period_start | tw.peak_flag | tw.err) !== 1'b0) begin errors++; $display("FAIL abort%0d_flags got ps=%b pf=%b err=%b exp 0", use_reset, tw.period_start, tw.peak_flag, tw.err); end
      rst_n = 1'b1;
      tw.enable = 1'b1;
      tick();
      checks++; if (tw.data_out !== -12'sd4) begin errors++; $display("FAIL abort%0d_restart got %0d exp -4", use_reset, tw.data_out); end
      checks++; if (tw.period_start !== 1'b1) begin errors++; $display("FAIL abort%0d_restart_ps got %b exp 1", use_reset, tw.period_start); end
      tick();
      checks++; if (tw.data_out !== -12'sd4 || tw.period_start !== 1'b0) begin errors++; $display("FAIL abort%0d_dwell got %0d ps=%b exp -4 ps=0", use_reset, tw.data_out, tw.period_start); end
      tick();
      checks++; if (tw.data_out !== -12'sd2) begin errors++; $display("FAIL abort%0d_rise got %0d exp -2", use_reset, tw.data_out); end
   endtask

   task automatic test_extremes();
      int e_d;
      idle_cfg(2047, 2047, 1023);
`ifdef TRI_WAVE_GEN_OFFSET_EN
      tw.offset = 12'sd100;
`endif
      tw.enable = 1'b1;
      for (int i = 0; i < 2051; i++) begin
         tick();
         if (i < 1024 || i == 2050) e_d = ext_bot;
         else if (i == 1024 || i == 2049) e_d = ext_mid;
         else e_d = 2047;
         checks++; if (tw.data_out !== e_d) begin errors++; $display("FAIL ext_data[%0d] got %0d exp %0d", i, tw.data_out, e_d); end
         checks++; if (tw.period_start !== (i == 0 || i == 2050)) begin errors++; $display("FAIL ext_ps[%0d] got %b", i, tw.period_start); end
         checks++; if (tw.peak_flag !== (i == 1025)) begin errors++; $display("FAIL ext_pf[%0d] got %b", i, tw.peak_flag); end
      end
`ifdef TRI_WAVE_GEN_OFFSET_EN
      tw.offset = 12'sd0;
`endif
   endtask

   initial begin
      rst_n     = 1'b0;
      tw.enable = 1'b0;
      tw.peak   = '0;
      tw.step   = '0;
      tw.hold   = '0;
`ifdef TRI_WAVE_GEN_OFFSET_EN
      tw.offset = '0;
`endif
      tick();
      test_reset();
      test_basic_ramp();
      test_saturation();
      test_invalid_config();
      test_mid_period_change();
      test_abort(1'b1);
      test_abort(1'b0);
      test_extremes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tri_wave_gen.md
# tri_wave_gen

Programmable signed triangle-wave stimulus source for the DSP measurement chain. It produces a symmetric ramp between `-peak` and `+peak` with programmable slope and dwell times. It also emits period and peak strobes, so downstream windowed measurement blocks (max/min/peak-to-peak) can be exercised and checked against known extremes.

## Interface
Parameters:
- `data_width`, 12: sample width, signed two's complement.
- `range_width`, 10: width of the dwell counter.

Ports:
- `clk_in`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `enable`  in  1  run request; low forces IDLE.
- `peak`  in  data_width  signed amplitude; valid range 1 .. 2^(data_width-1)-1.
- `step`  in  data_width-1  unsigned per-cycle increment; valid range ≥1.
- `hold`  in  range_width  extra dwell cycles at each extreme.
- `data_out`  out  data_width  signed sample, registered.
- `period_start`  out  1  one-cycle pulse on the first bottom sample of each period.
- `peak_flag`  out  1  one-cycle pulse on the first top sample of each period.
- `err`  out  1  high while `enable`=1 and latched config invalid.

## Operation
- States: IDLE, LO, RISE, HI, FALL.
- Reset (`rst_n`=0 at edge) or `enable`=0 produces these values next cycle:
  - state IDLE
  - `data_out`=0
  - `period_start`=0, `peak_flag`=0
  - `err`=0
- Config latch: `peak`, `step`, `hold` are sampled into `peak_l`, `step_l`, `hold_l` on every entry to LO, from IDLE or FALL. They stay frozen for the rest of the period.
- Invalid config is `peak`≤0 or `step`=0.
  - From IDLE: stay IDLE, `err`=1, `data_out`=0.
  - From FALL: go to IDLE, `err`=1.
  - Re-evaluated every cycle while in IDLE.
- IDLE→LO when `enable`=1 and config valid.
- LO:
  - `data_out`=`-peak_l` for `hold_l`+1 cycles.
  - `period_start`=1 on the first of these cycles.
  - Then →RISE.
- RISE:
  - `data_out` ← `data_out`+`step_l` each cycle.
  - If the sum ≥ `peak_l`: `data_out`=`peak_l` (saturate), →HI.
  - The first RISE sample is `-peak_l`+`step_l`.
- HI:
  - `data_out`=`peak_l` for `hold_l`+1 cycles, counting the entry cycle.
  - `peak_flag`=1 on the entry cycle.
  - Then →FALL.
- FALL: mirror of RISE. When the difference ≤ `-peak_l`: `data_out`=`-peak_l`, re-latch config, →LO. This entry cycle counts as the first LO cycle, with `period_start`.
- Arithmetic: sums are computed in data_width+1 bits before compare and clamp. No wrap is ever visible on `data_out`.
- Period length: 2·(`hold_l`+1) + 2·(ceil(2·`peak_l`/`step_l`)−1) cycles.

## Timing
- Latency from `enable` rising (valid config) to first `-peak` sample: 1 cycle.
- Latency from `enable` falling to `data_out`=0: 1 cycle.
- `hold` counter: range_width bits, counts 0..`hold_l`.
  - `hold_l`=0 gives a single-cycle extreme.
  - `hold_l`=2^range_width−1 gives the full dwell with no wrap.
- Config changes mid-period take effect at the next LO entry only.
- Simultaneous reset and `enable`: reset wins.
- Strobes never overlap. `period_start` and `peak_flag` are both 0 in IDLE.

## Configuration
- Macro `TRI_WAVE_GEN_OFFSET_EN`.
- Defined:
  - Adds input `offset` (signed, data_width), sampled at each config latch.
  - `data_out` = ramp + `offset_l`, saturated to [−2^(data_width-1), 2^(data_width-1)−1].
  - Strobes are unchanged.
- Undefined:
  - No `offset` port.
  - Output symmetric about 0, as described above.

## Test plan
- Basic ramp: `peak`=4, `step`=2, `hold`=1.
  - Expected sequence: −4,−4,−2,0,2,4,4,2,0,−2,−4,−4,…
  - Period 10 cycles.
  - `period_start` at each first −4, `peak_flag` at each first 4.
- Saturation: `peak`=4, `step`=3, `hold`=0.
  - Expected sequence: −4,−1,2,4,1,−2,−4,…
  - Extremes never exceed ±4.
- Invalid config:
  - `peak`=0, `enable`=1: `err`=1, `data_out`=0, no strobes.
  - Setting `peak`=5: next cycle `err`=0 and `data_out`=−5 with `period_start`.
- Mid-period change: `step` changed 2→1 during RISE. The old slope continues until the next LO, where the new slope applies.
- Reset and disable mid-FALL:
  - `rst_n`=0 for 1 cycle: next cycle `data_out`=0, strobes 0. Restart begins at −`peak` with `period_start`.
  - Same check for `enable`=0.
- Extremes (with `TRI_WAVE_GEN_OFFSET_EN`): `peak`=2047, `step`=2047, `hold`=1023, `offset`=100.
  - Top clamps at 2047.
  - Bottom equals −1947.
  - Dwell is 1024 cycles at each extreme.
